// File: rtl/vid_fetch.sv
`timescale 1ns/1ps
// vid_fetch: video word fetcher feeding the pixel shifter.
//
// The fetch for each 16-pixel screen column starts LEAD clocks before the
// column is displayed. The fetch address comes from the sync counters and
// the BK scroll register. The read goes to the memory arbiter over a
// req/ack handshake. The word is handed to the shifter with a one-cycle
// load strobe that lines up with x[3:0]=0 of its column.
//
// Ports
//   clk25        pixel clock
//   res_n        synchronous active-low reset
//   x, y         CounterX / CounterY from the sync generator
//   scroll       BK scroll register (low byte)
//   full_screen  1: 256-line mode, 0: only the bottom 64 BK lines are shown
//   vram_addr    video-RAM word address {row, col}
//   vram_req     read request, held until vram_ack
//   vram_ack     one-cycle acknowledge, vram_data valid with it
//   vram_data    read data
//   data         word for the shifter, valid with load_i
//   load_i       one-cycle shifter load strobe
//   underrun     one-cycle pulse when a word missed its deadline
module vid_fetch #(
  parameter int         H_TOTAL     = 704,
  parameter int         V_LAST      = 625,
  parameter logic [7:0] SCROLL_BASE = 8'hD8,
  parameter int         LEAD        = 16
) (
  input  logic        clk25,
  input  logic        res_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [7:0]  scroll,
  input  logic        full_screen,
  output logic [12:0] vram_addr,
  output logic        vram_req,
  input  logic        vram_ack,
  input  logic [15:0] vram_data,
  output logic [15:0] data,
  output logic        load_i,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] hold, hold_n, data_n;
  logic [12:0] addr_n;
  logic        req_n, load_n, under_n;

  logic        col0, start, deadline, vis, blank;
  logic [4:0]  col;
  logic [9:0]  ty;
  logic [7:0]  dline, row;

  // Fetch timing and target-row arithmetic.
  // Columns 1..31 start at x = 16n-16. Column 0 starts at the end of the
  // previous line and targets the next line. Each column's deadline is the
  // last clock of its lead window. The deadline for column 0 is therefore
  // the final pixel of the line.
  always_comb begin
    col0     = (x == 10'(H_TOTAL - LEAD));
    start    = col0 || (x[3:0] == 4'h0 && x < 10'(512 - LEAD));
    deadline = (x == 10'(H_TOTAL - 1)) ||
               (x[3:0] == 4'hF && x < 10'(512 - LEAD));
    col      = col0 ? 5'd0 : x[8:4] + 5'd1;
    if (!col0)                  ty = y;
    else if (y == 10'(V_LAST))  ty = '0;
    else                        ty = y + 10'd1;
    vis      = (ty < 10'd512);
    dline    = 8'(ty >> 1);               // every BK line is shown twice
    row      = dline + scroll - SCROLL_BASE;
    blank    = !full_screen && (dline < 8'd192);
  end

  // Next-state / next-output logic.
  // REQ and DONE both mean "a word is owed to the shifter at the deadline".
  // IDLE at a deadline means nothing was fetched, so no load is issued.
  always_comb begin
    state_n = state;
    req_n   = vram_req;
    addr_n  = vram_addr;
    hold_n  = hold;
    data_n  = data;
    load_n  = 1'b0;
    under_n = 1'b0;
    case (state)
      IDLE: begin
        if (start && vis) begin
          hold_n = '0;
          if (blank) begin
            state_n = DONE;                // blanked row: shifter gets zeros
          end else begin
            req_n   = 1'b1;
            addr_n  = {row, col};
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (vram_ack) begin
          hold_n  = vram_data;
          req_n   = 1'b0;
          state_n = DONE;
        end
        if (deadline) begin
          // An ack in the deadline cycle itself is on time and bypasses
          // the holding register straight to the shifter.
          load_n  = 1'b1;
          req_n   = 1'b0;
          state_n = IDLE;
          if (vram_ack) begin
            data_n = vram_data;
          end else begin
            data_n  = '0;
            under_n = 1'b1;
          end
        end
      end
      DONE: begin
        if (deadline) begin
          load_n  = 1'b1;
          data_n  = hold;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (!res_n) begin
      state     <= IDLE;
      hold      <= '0;
      vram_req  <= 1'b0;
      vram_addr <= '0;
      data      <= '0;
      load_i    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      vram_req  <= req_n;
      vram_addr <= addr_n;
      data      <= data_n;
      load_i    <= load_n;
      underrun  <= under_n;
    end
  end

endmodule

// File: tb/tb_vid_fetch.sv
`timescale 1ns/1ps
// Testbench for vid_fetch. The bench acts as the sync generator and the
// memory arbiter. A fetch-level reference model schedules, for every column
// fetch, the expected request window, address, load word and underrun.
module tb_vid_fetch;
  localparam int H_TOTAL = 704;
  localparam int V_LAST  = 625;

  logic        clk25 = 1'b0;
  logic        res_n = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [7:0]  scroll = 8'hD8;
  logic        full_screen = 1'b1;
  logic [12:0] vram_addr;
  logic        vram_req;
  logic        vram_ack = 1'b0;
  logic [15:0] vram_data = '0;
  logic [15:0] data;
  logic        load_i, underrun;

  vid_fetch dut (
    .clk25(clk25), .res_n(res_n), .x(x), .y(y), .scroll(scroll),
    .full_screen(full_screen), .vram_addr(vram_addr), .vram_req(vram_req),
    .vram_ack(vram_ack), .vram_data(vram_data), .data(data),
    .load_i(load_i), .underrun(underrun)
  );

  always #20 clk25 = ~clk25;

  int total = 0, bad = 0, cyc = 0;
  int          dmode = 2;          // ack delay after req appears; -1 random; >14 never
  bit          use_fixed = 1'b0;
  logic [15:0] fixed_word = '0;
  bit          rnd_scroll = 1'b0;

  bit          exp_req[int];
  logic [12:0] exp_addr[int];
  bit          exp_ld[int];
  logic [15:0] exp_dat[int];
  bit          exp_ur[int];
  logic [15:0] ack_map[int];

  // Reference model: if the current x/y is a fetch start, schedule
  // everything that fetch should produce from now on.
  task automatic model_start();
    int n, ty, dline, d, s, a;
    logic [15:0] w;
    n = -1;
    for (int k = 0; k < 32; k++)
      if (int'(x) == (16*k - 16 + H_TOTAL) % H_TOTAL) n = k;
    if (n < 0) return;
    if (n == 0) ty = (int'(y) == V_LAST) ? 0 : int'(y) + 1;
    else        ty = int'(y);
    if (ty >= 512) return;
    dline = ty / 2;
    s = cyc;
    if (!full_screen && dline < 192) begin
      exp_ld[s+16] = 1'b1; exp_dat[s+16] = '0;
      return;
    end
    a = ((dline + int'(scroll) - 216 + 256) % 256) * 32 + n;
    d = (dmode < 0) ? int'($urandom_range(0, 15)) : dmode;
    w = use_fixed ? fixed_word : 16'($urandom);
    if (d <= 14) begin
      for (int c = s + 1; c <= s + 1 + d; c++) begin
        exp_req[c] = 1'b1; exp_addr[c] = 13'(a);
      end
      ack_map[s+1+d] = w;
      exp_ld[s+16] = 1'b1; exp_dat[s+16] = w;
    end else begin
      for (int c = s + 1; c <= s + 15; c++) begin
        exp_req[c] = 1'b1; exp_addr[c] = 13'(a);
      end
      ack_map[s+16] = 16'hDEAD;       // late ack after the drop: must be ignored
      exp_ld[s+16] = 1'b1; exp_dat[s+16] = '0; exp_ur[s+16] = 1'b1;
    end
  endtask

  // One pixel clock: schedule, drive ack, compare at the falling edge,
  // then advance the sync counters just after the rising edge.
  task automatic one_cycle();
    bit er, el, eu;
    model_start();
    if (ack_map.exists(cyc)) begin vram_ack = 1'b1; vram_data = ack_map[cyc]; end
    else begin vram_ack = 1'b0; vram_data = 16'($urandom); end
    @(negedge clk25);
    er = exp_req.exists(cyc); el = exp_ld.exists(cyc); eu = exp_ur.exists(cyc);
    total++;
    if (vram_req !== er) begin
      bad++; $display("FAIL req y=%0d x=%0d got=%b exp=%b", y, x, vram_req, er);
    end
    if (er) begin
      total++;
      if (vram_addr !== exp_addr[cyc]) begin
        bad++; $display("FAIL addr y=%0d x=%0d got=%h exp=%h", y, x, vram_addr, exp_addr[cyc]);
      end
    end
    total++;
    if (load_i !== el) begin
      bad++; $display("FAIL load y=%0d x=%0d got=%b exp=%b", y, x, load_i, el);
    end
    if (el) begin
      total++;
      if (data !== exp_dat[cyc]) begin
        bad++; $display("FAIL data y=%0d x=%0d got=%h exp=%h", y, x, data, exp_dat[cyc]);
      end
    end
    total++;
    if (underrun !== eu) begin
      bad++; $display("FAIL underrun y=%0d x=%0d got=%b exp=%b", y, x, underrun, eu);
    end
    @(posedge clk25); #1;
    cyc++;
    if (rnd_scroll) scroll = 8'($urandom);
    if (int'(x) == H_TOTAL - 1) begin
      x = '0;
      y = (int'(y) == V_LAST) ? 10'd0 : y + 10'd1;
    end else begin
      x = x + 10'd1;
    end
  endtask

  task automatic start_at(int x0, int y0);
    res_n = 1'b0; vram_ack = 1'b0;
    repeat (2) begin @(posedge clk25); #1; cyc++; end
    exp_req.delete(); exp_addr.delete(); exp_ld.delete();
    exp_dat.delete(); exp_ur.delete(); ack_map.delete();
    res_n = 1'b1; x = 10'(x0); y = 10'(y0);
  endtask

  task automatic run_to(int xt, int yt);
    int k = 0;
    while (!(int'(x) == xt && int'(y) == yt) && k < 3000) begin one_cycle(); k++; end
    if (k >= 3000) begin
      total++; bad++; $display("FAIL run_to target y=%0d x=%0d not reached", yt, xt);
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0; x = 10'd688; y = 10'd10; full_screen = 1'b1; scroll = 8'hD8;
    for (int i = 0; i < 3; i++) begin
      vram_ack = (i % 2 == 0); vram_data = 16'hFFFF;
      @(posedge clk25); #1;
      total++;
      if ({vram_req, vram_addr, data, load_i, underrun} !== 32'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got req=%b addr=%h data=%h load=%b ur=%b exp all 0",
                 i, vram_req, vram_addr, data, load_i, underrun);
      end
      x = x + 10'd1;
    end
    vram_ack = 1'b0;
  endtask

  task automatic test_addressing();
    scroll = 8'hD8; full_screen = 1'b1; dmode = 2; use_fixed = 1'b0;
    start_at(0, 10);
    run_to(32, 10);
    total++;
    if (vram_addr !== 13'h0A2) begin
      bad++; $display("FAIL addr_y10_x32 got=%h exp=%h", vram_addr, 13'h0A2);
    end
    repeat (8) one_cycle();
    start_at(680, 625);
    run_to(689, 625);
    total++;
    if (vram_req !== 1'b1 || vram_addr !== 13'h000) begin
      bad++; $display("FAIL addr_y625_col0 got req=%b addr=%h exp req=1 addr=000", vram_req, vram_addr);
    end
    run_to(20, 0);
  endtask

  task automatic test_scroll_wrap();
    scroll = 8'hD7; full_screen = 1'b1; dmode = 3;
    use_fixed = 1'b1; fixed_word = 16'hA5A5;
    start_at(684, 625);
    run_to(689, 625);
    total++;
    if (vram_addr !== 13'h1FE0) begin
      bad++; $display("FAIL scroll_wrap_addr got=%h exp=%h", vram_addr, 13'h1FE0);
    end
    run_to(0, 0);
    total++;
    if (load_i !== 1'b1 || data !== 16'hA5A5) begin
      bad++; $display("FAIL scroll_wrap_load got load=%b data=%h exp load=1 data=a5a5", load_i, data);
    end
    repeat (4) one_cycle();
    use_fixed = 1'b0;
  endtask

  task automatic test_extended();
    int nreq = 0, nld = 0;
    scroll = 8'hD8; full_screen = 1'b0; dmode = 2;
    start_at(0, 100);
    for (int i = 0; i < 520; i++) begin
      one_cycle();
      if (vram_req === 1'b1) nreq++;
      if (load_i === 1'b1) nld++;
    end
    total++;
    if (nreq != 0) begin
      bad++; $display("FAIL ext_blank_req got=%0d req cycles exp=0", nreq);
    end
    total++;
    if (nld != 31) begin
      bad++; $display("FAIL ext_blank_loads got=%0d exp=31", nld);
    end
    start_at(0, 400);
    run_to(1, 400);
    total++;
    if (vram_req !== 1'b1 || vram_addr !== 13'h1901) begin
      bad++; $display("FAIL ext_visible got req=%b addr=%h exp req=1 addr=1901", vram_req, vram_addr);
    end
    repeat (40) one_cycle();
    full_screen = 1'b1;
  endtask

  task automatic test_underrun();
    scroll = 8'hD8; full_screen = 1'b1; dmode = 255;
    start_at(0, 20);
    run_to(15, 20);
    total++;
    if (vram_req !== 1'b1) begin
      bad++; $display("FAIL underrun_req_held got=%b exp=1", vram_req);
    end
    run_to(16, 20);
    total++;
    if (vram_req !== 1'b0 || underrun !== 1'b1 || load_i !== 1'b1 || data !== 16'h0) begin
      bad++; $display("FAIL underrun_pulse got req=%b ur=%b load=%b data=%h exp 0/1/1/0000",
                      vram_req, underrun, load_i, data);
    end
    run_to(17, 20);
    total++;
    if (vram_req !== 1'b1 || underrun !== 1'b0 || vram_addr !== 13'h142) begin
      bad++; $display("FAIL underrun_next got req=%b ur=%b addr=%h exp 1/0/142",
                      vram_req, underrun, vram_addr);
    end
    repeat (20) one_cycle();
  endtask

  task automatic test_boundary_ack();
    scroll = 8'hD8; full_screen = 1'b1; dmode = 14;
    use_fixed = 1'b1; fixed_word = 16'h1234;
    start_at(0, 30);
    run_to(15, 30);
    total++;
    if (vram_req !== 1'b1) begin
      bad++; $display("FAIL boundary_req got=%b exp=1", vram_req);
    end
    run_to(16, 30);
    total++;
    if (load_i !== 1'b1 || data !== 16'h1234 || underrun !== 1'b0) begin
      bad++; $display("FAIL boundary_ack got load=%b data=%h ur=%b exp 1/1234/0", load_i, data, underrun);
    end
    repeat (4) one_cycle();
    use_fixed = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ys[6] = '{0, 150, 383, 510, 620, 625};
    dmode = -1; use_fixed = 1'b0; rnd_scroll = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      full_screen = 1'($urandom_range(0, 1));
      start_at(int'($urandom_range(0, H_TOTAL - 1)), ys[seg]);
      repeat (420) one_cycle();
    end
    rnd_scroll = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addressing();
    test_scroll_wrap();
    test_extended();
    test_underrun();
    test_boundary_ack();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
